// File: rtl/lut4_cfg_ctrl_pkg.sv
// ============================================================================
// Module   : lut_cfg_pkg
// Brief    : Shared widths and controller state encoding for lut4_cfg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_cfg_pkg;

  localparam int LUT_K_DEFAULT = 4;
  localparam int CFG_W         = 2 ** LUT_K_DEFAULT;
  localparam int CNT_W         = LUT_K_DEFAULT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOADED = 2'd2
  } cfg_state_e;

endpackage

`default_nettype wire

// File: rtl/lut4_cfg_ctrl_if.sv
// ============================================================================
// Module   : lut4_cfg_ctrl_if
// Brief    : Truth-table valid/ready channel (cfg_par with LUT_CFG_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lut4_cfg_ctrl_if
  import lut_cfg_pkg::*;
#(
  parameter int DATA_W = CFG_W
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;
`ifdef LUT_CFG_PARITY_EN
  logic              cfg_par;
`endif

  modport master (
    output cfg_valid,
    output cfg_data,
`ifdef LUT_CFG_PARITY_EN
    output cfg_par,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
`ifdef LUT_CFG_PARITY_EN
    input  cfg_par,
`endif
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/lut4_cfg_ctrl_cell.sv
// ============================================================================
// Module   : lut4_cell
// Brief    : LUT cell with serial configuration chain and 2^K:1 read mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut4_cell
  import lut_cfg_pkg::*;
#(
  parameter int LUT_K = LUT_K_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_din,
  input  logic [LUT_K-1:0] lut_in,
  output logic             lut_out
);

  localparam int CFG_WIDTH = 2 ** LUT_K;

  logic [CFG_WIDTH-1:0] chain_q;

  // First bit shifted in ends up at the top after CFG_WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else if (cfg_en) begin
      chain_q <= {chain_q[CFG_WIDTH-2:0], cfg_din};
    end
  end

  assign lut_out = chain_q[lut_in];

endmodule

`default_nettype wire

// File: rtl/lut4_cfg_ctrl.sv
// ============================================================================
// Module   : lut4_cfg_ctrl
// Brief    : Serial configuration controller for one LUT cell; masks X until
//            loaded. Optional parity check enabled by LUT_CFG_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut4_cfg_ctrl
  import lut_cfg_pkg::*;
#(
  parameter int LUT_K = LUT_K_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  lut4_cfg_ctrl_if.slave   cfg,
  input  logic [LUT_K-1:0] lut_in,
  output logic             X,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int               CFG_WIDTH = 2 ** LUT_K;
  localparam logic [LUT_K-1:0] CNT_LAST  = '1;

  cfg_state_e           state_q, state_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
  logic [LUT_K-1:0]     cnt_q, cnt_d;
  logic                 loaded_q, loaded_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 par_ok;
  logic                 shift_en;
  logic                 lut_raw;

  assign cfg.cfg_ready = (state_q != SHIFT);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

`ifdef LUT_CFG_PARITY_EN
  logic perr_q;
  logic err_q;

  assign par_ok = ~(^{cfg.cfg_data, cfg.cfg_par});

  // Rejection is flagged one edge after the accept that carried bad parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      perr_q <= accept && !par_ok;
      err_q  <= perr_q;
    end
  end

  assign cfg_err = err_q;
`else
  assign par_ok  = 1'b1;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE, LOADED: begin
        if (accept && par_ok) begin
          shadow_d = cfg.cfg_data;
          cnt_d    = '0;
          loaded_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        shadow_d = {shadow_q[CFG_WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = LOADED;
          loaded_d = 1'b1;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
    end
  end

  lut4_cell #(
    .LUT_K (LUT_K)
  ) u_cell (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (shift_en),
    .cfg_din (shadow_q[CFG_WIDTH-1]),
    .lut_in  (lut_in),
    .lut_out (lut_raw)
  );

  assign X    = loaded_q & lut_raw;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lut4_cfg_ctrl.sv
// ============================================================================
// Module   : tb_lut4_cfg_ctrl
// Brief    : Randomized self-checking bench for lut4_cfg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut4_cfg_ctrl;
  import lut_cfg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lut_in;
  logic       X, busy, done, cfg_err;

  lut4_cfg_ctrl_if cfg_if ();

  lut4_cfg_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_if),
    .lut_in  (lut_in),
    .X       (X),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  int acc_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  end

  // Reference model: the truth table last completed and whether it is live.
  logic [15:0] m_tab    = '0;
  bit          m_loaded = 1'b0;

  function automatic logic m_x(input logic [3:0] sel);
    return m_loaded ? m_tab[sel] : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_cfg(input logic [15:0] d, input logic p);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
`ifdef LUT_CFG_PARITY_EN
    cfg_if.cfg_par   = p;
`endif
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lut_in = i[3:0];
      #1;
      chk(tag, X, m_x(lut_in));
    end
  endtask

  task automatic do_load(input logic [15:0] d, input bit hold);
    int k;
    int acc0;
    @(negedge clk);
    chk("ready_pre", cfg_if.cfg_ready, 1);
    acc0 = n_acc;
    drive_cfg(d, ^d);
    @(negedge clk);
    if (!hold) cfg_if.cfg_valid = 1'b0;
    m_loaded = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ready", cfg_if.cfg_ready, 0);
    k = 0;
    while (!done && k < 40) begin
      lut_in = 4'($urandom);
      #1;
      chk("x_masked", X, m_x(lut_in));
      @(negedge clk);
      k++;
    end
    cfg_if.cfg_valid = 1'b0;
    chk("load_latency", k, 16);
    chk("done_busy", busy, 0);
    chk("done_ready", cfg_if.cfg_ready, 1);
    m_tab    = d;
    m_loaded = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("accept_count", n_acc - acc0, 1);
  endtask

  initial begin
    int k;
    int a0;
    int spacing;

    rst              = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
`ifdef LUT_CFG_PARITY_EN
    cfg_if.cfg_par   = 1'b0;
`endif
    lut_in = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_x", X, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_x", X, 0);

    // AND4
    do_load(16'h8000, 1'b0);
    sweep("and4");

    // XOR4 with cfg_valid held through the shift
    do_load(16'h6996, 1'b1);
    sweep("xor4");

`ifdef LUT_CFG_PARITY_EN
    do_load(16'h8000, 1'b0);
    @(negedge clk);
    drive_cfg(16'h0001, 1'b0);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("perr_busy", busy, 0);
    chk("perr_early", cfg_err, 0);
    @(negedge clk);
    chk("perr_pulse", cfg_err, 1);
    chk("perr_nodone", done, 0);
    @(negedge clk);
    chk("perr_clear", cfg_err, 0);
    sweep("perr_keep");
    do_load(16'h0001, 1'b0);
    sweep("par_retry");
`endif

    // Reset after the 8th shift
    @(negedge clk);
    drive_cfg(16'hFFFE, ^16'hFFFE);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    repeat (8) @(negedge clk);
    lut_in = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    m_tab    = '0;
    m_loaded = 1'b0;
    chk("mid_rst_x", X, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cfg_if.cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    sweep("post_rst");
    do_load(16'hFFFE, 1'b0);
    sweep("or4");

    // Random truth tables
    for (int n = 0; n < 5; n++) begin
      do_load(16'($urandom), 1'($urandom));
      sweep("rand");
    end

    // Back-to-back loads
    @(negedge clk);
    a0 = acc_cyc.size();
    drive_cfg(16'h0F0F, ^16'h0F0F);
    @(negedge clk);
    cfg_if.cfg_data = 16'hF0F0;
`ifdef LUT_CFG_PARITY_EN
    cfg_if.cfg_par  = ^16'hF0F0;
`endif
    m_loaded = 1'b0;
    k = 0;
    while (acc_cyc.size() - a0 < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    cfg_if.cfg_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size() - a0, 2);
    spacing = (acc_cyc.size() >= a0 + 2) ? acc_cyc[a0+1] - acc_cyc[a0] : -1;
    chk("b2b_spacing", spacing, 17);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done", done, 1);
    m_tab    = 16'hF0F0;
    m_loaded = 1'b1;
    sweep("b2b");
    @(negedge clk);
    lut_in = 4'b0100;
    #1;
    chk("b2b_b1", X, 1);
    lut_in = 4'b1011;
    #1;
    chk("b2b_b0", X, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lut4_cfg_ctrl.md
# lut4_cfg_ctrl

Configuration controller for the 4-input LUT cell of the FPGA architecture exercises. Accepts a 16-bit truth table over a valid/ready handshake, shifts it serially into the LUT's configuration chain, and gates the LUT output until a complete configuration is in place. It sits between the bitstream source (bench or loader) and one LUT cell, and is the only writer of that cell's configuration.

## Interface
- `LUT_K`, default 4: number of LUT inputs; configuration width is `CFG_W = 2**LUT_K` (16).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: truth table offered.
- `cfg_ready` out 1: controller can accept a truth table.
- `cfg_data` in CFG_W: truth table; bit i is the output for `lut_in == i`.
- `cfg_par` in 1: even-parity bit over `cfg_data`. Present only with `LUT_CFG_PARITY_EN`.
- `lut_in` in LUT_K: LUT select inputs; `lut_in[3]` = A, `[2]` = B, `[1]` = C, `[0]` = D.
- `X` out 1: LUT output, forced 0 while unconfigured or loading.
- `busy` out 1: a shift is in progress.
- `done` out 1: one-cycle pulse when a load completes.
- `cfg_err` out 1: one-cycle pulse on a rejected load. Constant 0 without the macro.

## Operation
- States:
  - `IDLE`: no valid config.
  - `SHIFT`: loading.
  - `LOADED`: config valid.
- Transitions:
  - `IDLE`→`SHIFT` on accept.
  - `SHIFT`→`LOADED` after 16 shifts.
  - `LOADED`→`SHIFT` on accept.
  - No other transitions.
- Handshake:
  - Accept when `cfg_valid && cfg_ready`.
  - `cfg_ready` = 1 in `IDLE` and `LOADED`, 0 in `SHIFT`.
  - `cfg_valid` held during `SHIFT` is not accepted until `LOADED`.
- On accept:
  - `cfg_data` is captured into a shadow register.
  - The 4-bit shift counter is cleared.
  - The loaded flag is cleared, so `X` = 0 from the next cycle.
- Shift order is MSB first: one bit per cycle into the chain. After 16 shifts, chain bit i = `cfg_data[i]`.
- `X` = `chain[lut_in]` when the loaded flag is set, else 0. The path from `lut_in` to `X` is combinational.
- Counter wraps 15→0 on the final shift; that same edge sets the loaded flag and `done`.
- Reset mid-shift aborts the load:
  - State returns to `IDLE`.
  - Chain, shadow, counter and flags clear to 0.
  - `X` = 0 immediately, because the reset is asynchronous.
- Reset values:
  - `cfg_ready` = 1.
  - `busy` = 0.
  - `done` = 0.
  - `cfg_err` = 0.
  - `X` = 0.

## Timing
- Accept at edge N:
  - `busy` = 1 and `cfg_ready` = 0 from after edge N.
  - Shifts occur on edges N+1 … N+16.
- Edge N+16:
  - State becomes `LOADED`.
  - `busy` = 0, `cfg_ready` = 1, `done` = 1 for one cycle.
  - `X` is valid after this edge.
- Load latency is 16 cycles, accept to `done`. Back-to-back throughput is one load per 17 cycles.
- Accept in `LOADED` masks `X` from edge N+1 until edge N+16+1's cycle begins, i.e. `X` is 0 for 16 cycles.

## Configuration
- Macro `LUT_CFG_PARITY_EN`.
- Defined:
  - `cfg_par` port exists.
  - Parity fails when `^{cfg_data, cfg_par}` = 1.
  - On failure the handshake still completes, `cfg_err` pulses on edge N+1, and the state does not change.
  - Chain contents and loaded flag are retained, so a previous valid config keeps driving `X`.
  - `done` is not asserted.
- Undefined:
  - No `cfg_par` port.
  - Every accepted load is shifted.
  - `cfg_err` is tied to 0.

## Structure
- Package `lut_cfg_pkg` contains:
  - The state enum typedef (`IDLE`/`SHIFT`/`LOADED`).
  - The `LUT_K` default.
  - The `CFG_W` localparam.
  - The counter width.
- Sub-module `lut4_cell`:
  - CFG_W-bit configuration shift chain with `cfg_en`/`cfg_din` inputs.
  - 2^K:1 read mux on `lut_in`.
  - Raw unmasked output.
- The controller instantiates `lut4_cell` and applies the output mask.

## Test plan
- Reset, `lut_in`=4'b1111 → `X`=0, `cfg_ready`=1, `busy`=0, `done`=0.
- Load 16'h8000 (AND4) → `done` exactly 16 cycles after accept; sweep all 16 inputs, `X`=1 only at 4'b1111.
- Load 16'h6996 (XOR4) from `LOADED`:
  - `X`=0 for all 16 shift cycles.
  - `cfg_valid` held high through `SHIFT` produces one accept only.
  - The sweep then matches the odd-parity function.
- Assert `rst` after the 8th shift of 16'hFFFE → `X`, `busy` = 0 immediately; reload 16'hFFFE completes, `X`=0 only at 4'b0000.
- With `LUT_CFG_PARITY_EN`:
  - After 16'h8000 is loaded, offer 16'h0001 with `cfg_par`=0.
  - Expect a `cfg_err` pulse, no `done`, and `X` still AND4.
  - Retry with `cfg_par`=1; expect `X`=1 only at 4'b0000.
- Two back-to-back loads 16'h0F0F, 16'hF0F0 → accepts 17 cycles apart; final `X` = `lut_in[2]`.
